dmem_access_ctrl: RTL and testbench

//  MEM-stage data-memory access controller. It sits after the EX/MEM pipeline register and generates the
//  EX_MEM_stall_from_DCache hold signal. It consumes the latched op/addr/store-data, runs one blocking
//  req/ack transaction on the data bus, aligns and extends load data, and releases the stall when done.

---
 rtl/dmem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: one blocking req/ack bus transaction per load/store,
// holding EX/MEM via stall, with store lane steering and load alignment/extension.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_op,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        mis_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, state_nxt;
  logic               op_vld, op_store, misalign, start, tmo_hit;
  logic [CNT_W-1:0]   cnt;
  logic               load_p1, sign_p1;
  logic [1:0]         size_p1, lo_p1;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   store_strb = 4'b0001 << lo;
      2'b01:   store_strb = 4'b0011 << {lo[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] lo,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = rdata >> {lo, 3'b000};
    case (size)
      2'b00:   load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  assign op_vld   = (mem_op == 2'b01) || (mem_op == 2'b10);
  assign op_store = (mem_op == 2'b10);
  assign misalign = ((mem_size == 2'b01) && mem_addr[0]) ||
                    (mem_size[1] && (mem_addr[1:0] != 2'b00));
  assign start    = (state == IDLE) && op_vld && !misalign;
  // TIMEOUT of 0 disables the watchdog; the counter may then wrap harmlessly.
  assign tmo_hit  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack || tmo_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus launch (IDLE->REQ) and completion (REQ->DONE) registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      mis_err   <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      load_p1   <= 1'b0;
      sign_p1   <= 1'b0;
      size_p1   <= '0;
      lo_p1     <= '0;
    end else begin
      mis_err  <= (state == IDLE) && op_vld && misalign;
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= op_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_wstrb <= op_store ? store_strb(mem_size, mem_addr[1:0]) : 4'b0000;
            bus_wdata <= op_store ? store_lanes(mem_size, mem_wdata) : 32'h0;
            load_p1   <= !op_store;
            sign_p1   <= mem_sign;
            size_p1   <= mem_size;
            lo_p1     <= mem_addr[1:0];
            cnt       <= '0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            ld_valid <= load_p1;
            if (load_p1) ld_data <= load_extend(bus_rdata, lo_p1, size_p1, sign_p1);
          end else if (tmo_hit) begin
            bus_req  <= 1'b0;
            bus_err  <= 1'b1;
            ld_valid <= load_p1;
            ld_data  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized ops checked
// against a byte-level behavioural model of the access rules.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mem_op = '0, mem_size = '0;
  logic        mem_sign = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        stall, ld_valid, mis_err, bus_err, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld = '0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .ld_data(ld_data),
    .ld_valid(ld_valid), .mis_err(mis_err), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [31:0] a);
    return (a % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] a);
    logic [3:0] s;
    int k, n;
    k = int'(a % 4);
    n = nbytes(size);
    s = '0;
    for (int i = 0; i < 4; i++) if (i >= k && i < k + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
    longint unsigned v, m;
    int n, k;
    n = nbytes(size);
    k = int'(a % 4);
    v = 64'(rd) >> (8 * k);
    if (n < 4) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = v & m;
      if (sgn && v[8*n-1]) v = v | ~m;
    end
    return v[31:0];
  endfunction

  // Presents one op at posedge+1 and follows it to completion; returns in IDLE at posedge+1.
  task automatic do_op(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int ack_at, output int stall_cyc, output int req_cyc);
    bit vld, is_ld, tmo;
    int exp_req;
    mem_op = op; mem_size = size; mem_sign = sgn; mem_addr = addr; mem_wdata = wd;
    bus_ack = 1'b0;
    vld = (op == 2'b01) || (op == 2'b10);
    is_ld = (op == 2'b01);
    stall_cyc = 0;
    req_cyc = 0;
    @(negedge clk);
    if (!vld || model_mis(size, addr)) begin
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nop_stall: got %b want 0", stall); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL nop_req: got %b want 0", bus_req); end
      @(posedge clk); #1;
      checks++; if (mis_err !== bit'(vld)) begin errors++; $display("FAIL mis_err: got %b want %b", mis_err, vld); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", bus_req); end
      mem_op = 2'b00;
      return;
    end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL idle_stall: got %b want 1", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus_req); end
    stall_cyc += int'(stall);
    @(posedge clk); #1;
    tmo = !(ack_at >= 1 && ack_at <= TO);
    exp_req = tmo ? TO : ack_at;
    for (int n = 1; n <= exp_req; n++) begin
      bus_ack = (n == ack_at);
      bus_rdata = (n == ack_at) ? rd : $urandom;
      @(negedge clk);
      stall_cyc += int'(stall);
      req_cyc += int'(bus_req);
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL req_req: got %b want 1", bus_req); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL req_stall: got %b want 1", stall); end
      checks++; if (bus_we !== bit'(!is_ld)) begin errors++; $display("FAIL req_we: got %b want %b", bus_we, !is_ld); end
      checks++; if (bus_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL req_addr: got %h want %h", bus_addr, {addr[31:2], 2'b00}); end
      checks++; if (bus_wstrb !== (is_ld ? 4'b0000 : model_strb(size, addr))) begin errors++; $display("FAIL req_wstrb: got %b want %b", bus_wstrb, is_ld ? 4'b0000 : model_strb(size, addr)); end
      if (!is_ld) begin
        checks++; if (bus_wdata !== model_wdata(size, wd)) begin errors++; $display("FAIL req_wdata: got %h want %h", bus_wdata, model_wdata(size, wd)); end
      end
      checks++; if ({ld_valid, bus_err, mis_err} !== 3'b000) begin errors++; $display("FAIL req_pulses: got %b want 000", {ld_valid, bus_err, mis_err}); end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    if (tmo) exp_ld = '0;
    else if (is_ld) exp_ld = model_load(size, sgn, addr, rd);
    bus_ack = $urandom_range(0, 1);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL done_stall: got %b want 0", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b want 0", bus_req); end
    checks++; if (ld_valid !== bit'(is_ld)) begin errors++; $display("FAIL done_ld_valid: got %b want %b", ld_valid, is_ld); end
    checks++; if (bus_err !== bit'(tmo)) begin errors++; $display("FAIL done_bus_err: got %b want %b", bus_err, tmo); end
    checks++; if (ld_data !== exp_ld) begin errors++; $display("FAIL done_ld_data: got %h want %h", ld_data, exp_ld); end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    mem_op = 2'b00;
    checks++; if ({ld_valid, bus_err, bus_req} !== 3'b000) begin errors++; $display("FAIL post_done: got %b want 000", {ld_valid, bus_err, bus_req}); end
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({bus_req, bus_we, ld_valid, mis_err, bus_err, stall} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {bus_req, bus_we, ld_valid, mis_err, bus_err, stall}); end
    checks++; if ({bus_addr, bus_wdata, ld_data, bus_wstrb} !== 100'b0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus_addr, bus_wdata, ld_data, bus_wstrb}); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_word_load;
    int sc, rc;
    do_op(2'b01, 2'b10, 1'b0, 32'h1C000010, 32'h0, 32'hDEADBEEF, 3, sc, rc);
    checks++; if (sc !== 4) begin errors++; $display("FAIL wl_stall_cycles: got %0d want 4", sc); end
    checks++; if (ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_data: got %h want deadbeef", ld_data); end
    checks++; if (bus_wstrb !== 4'b0000) begin errors++; $display("FAIL wl_wstrb: got %b want 0000", bus_wstrb); end
  endtask

  task automatic test_byte_load;
    int sc, rc;
    do_op(2'b01, 2'b00, 1'b1, 32'h1C000103, 32'h0, 32'h80123456, 1, sc, rc);
    checks++; if (ld_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", ld_data); end
    checks++; if (sc !== 2) begin errors++; $display("FAIL lb_stall_cycles: got %0d want 2", sc); end
    do_op(2'b01, 2'b00, 1'b0, 32'h1C000103, 32'h0, 32'h80123456, 2, sc, rc);
    checks++; if (ld_data !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned: got %h want 00000080", ld_data); end
  endtask

  task automatic test_half_store;
    int sc, rc;
    do_op(2'b10, 2'b01, 1'b0, 32'h20000002, 32'h0000ABCD, 32'h0, 1, sc, rc);
    checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", bus_we); end
    checks++; if (bus_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", bus_wstrb); end
    checks++; if (bus_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", bus_wdata); end
  endtask

  task automatic test_misaligned;
    int sc, rc;
    do_op(2'b01, 2'b10, 1'b0, 32'h20000002, 32'h0, 32'h0, 1, sc, rc);
    checks++; if (sc !== 0) begin errors++; $display("FAIL mis_stall_cycles: got %0d want 0", sc); end
    @(negedge clk);
    checks++; if (mis_err !== 1'b1) begin errors++; $display("FAIL mis_hold: got %b want 1", mis_err); end
    @(posedge clk); #1;
    checks++; if ({mis_err, bus_req} !== 2'b00) begin errors++; $display("FAIL mis_pulse: got %b want 00", {mis_err, bus_req}); end
  endtask

  task automatic test_timeout;
    int sc, rc;
    do_op(2'b01, 2'b10, 1'b0, 32'h30000008, 32'h0, 32'h12345678, 0, sc, rc);
    checks++; if (rc !== TO) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", rc, TO); end
    checks++; if (sc !== TO + 1) begin errors++; $display("FAIL to_stall_cycles: got %0d want %0d", sc, TO + 1); end
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL to_ld_data: got %h want 0", ld_data); end
  endtask

  task automatic test_reset_mid_req;
    int sc, rc;
    mem_op = 2'b01; mem_size = 2'b10; mem_addr = 32'h40000000;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmr_req_on: got %b want 1", bus_req); end
    #2;
    rst = 1'b0;
    mem_op = 2'b00;
    #1;
    checks++; if ({bus_req, stall, ld_valid, bus_err} !== 4'b0) begin errors++; $display("FAIL rmr_async: got %b want 0000", {bus_req, stall, ld_valid, bus_err}); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ld = '0;
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL rmr_ld_data: got %h want 0", ld_data); end
  endtask

  task automatic test_back_to_back;
    int sc, rc;
    do_op(2'b01, 2'b10, 1'b0, 32'h50000004, 32'h0, 32'hCAFEF00D, 1, sc, rc);
    checks++; if (sc !== 2) begin errors++; $display("FAIL b2b_first: got %0d want 2", sc); end
    do_op(2'b10, 2'b00, 1'b0, 32'h50000005, 32'h000000A5, 32'h0, 1, sc, rc);
    checks++; if (rc !== 1) begin errors++; $display("FAIL b2b_second_req: got %0d want 1", rc); end
    checks++; if (ld_data !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_ld_hold: got %h want cafef00d", ld_data); end
  endtask

  task automatic test_ack_ignored;
    for (int i = 0; i < 3; i++) begin
      bus_ack = 1'b1;
      bus_rdata = $urandom;
      @(negedge clk);
      checks++; if ({stall, bus_req, ld_valid} !== 3'b000) begin errors++; $display("FAIL ack_idle: got %b want 000", {stall, bus_req, ld_valid}); end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_random;
    int sc, rc;
    for (int i = 0; i < 80; i++) begin
      do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, $urandom_range(0, 6), sc, rc);
    end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_store;
    test_misaligned;
    test_timeout;
    test_reset_mid_req;
    test_back_to_back;
    test_ack_ignored;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
